// File: rtl/bat_amateur_pkg.sv
// Shared definitions for the BatAmateur loader/dump blocks: default bus widths,
// the dump FSM state encoding and state-decode helpers.
package bat_amateur_pkg;

    localparam int BAT_ADDRESS_WIDTH = 16;
    localparam int BAT_DATA_WIDTH    = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_READ     = 3'd2,
        ST_CAPTURE  = 3'd3,
        ST_WAIT_ACK = 3'd4,
        ST_FINISH   = 3'd5
    } dump_state_e;

    // HALT is requested from START up to, but not including, FINISH.
    function automatic logic state_holds_halt(input dump_state_e s);
        logic v;
        case (s)
            ST_SETTLE, ST_READ, ST_CAPTURE, ST_WAIT_ACK: v = 1'b1;
            default:                                     v = 1'b0;
        endcase
        return v;
    endfunction

    function automatic logic state_owns_bus(input dump_state_e s);
        logic v;
        case (s)
            ST_READ, ST_CAPTURE: v = 1'b1;
            default:             v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/bat_amateur_mem_dump.sv
// Memory dump engine: halts the core, walks [START_ADDR..END_ADDR] (wrapping),
// and streams {address, word} over a valid/ready handshake.
module bat_amateur_mem_dump
    import bat_amateur_pkg::*;
#(
    parameter int ADDRESS_WIDTH = BAT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = BAT_DATA_WIDTH,
    parameter int HALT_SETTLE   = 2
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     START,
    input  logic [ADDRESS_WIDTH-1:0] START_ADDR,
    input  logic [ADDRESS_WIDTH-1:0] END_ADDR,
    output logic                     HALT,
    output logic [ADDRESS_WIDTH-1:0] ADDRESS_BUS,
    output logic                     ADDR_OE,
    output logic                     MEM_RD,
    input  logic [DATA_WIDTH-1:0]    DATA_BUS,
    output logic [ADDRESS_WIDTH-1:0] DUMP_ADDR,
    output logic [DATA_WIDTH-1:0]    DUMP_DATA,
    output logic                     DUMP_VALID,
    input  logic                     DUMP_READY,
    output logic                     BUSY,
    output logic                     DONE
);

    localparam int SW = (HALT_SETTLE > 1) ? $clog2(HALT_SETTLE) : 1;
    localparam logic [SW-1:0]          SETTLE_LOAD = SW'(HALT_SETTLE - 1);
    localparam logic [ADDRESS_WIDTH:0] CNT_ONE     = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

    dump_state_e               r_state;
    dump_state_e               w_state_next;
    logic [ADDRESS_WIDTH-1:0]  r_addr;
    logic [ADDRESS_WIDTH-1:0]  w_addr_next;
    logic [ADDRESS_WIDTH:0]    r_count;
    logic [ADDRESS_WIDTH:0]    w_count_next;
    logic [SW-1:0]             r_settle;
    logic [SW-1:0]             w_settle_next;
    logic [ADDRESS_WIDTH-1:0]  w_span;
    logic                      w_handshake;

    logic                      r_halt;
    logic [ADDRESS_WIDTH-1:0]  r_address_bus;
    logic                      r_addr_oe;
    logic                      r_mem_rd;
    logic [ADDRESS_WIDTH-1:0]  r_dump_addr;
    logic [DATA_WIDTH-1:0]     r_dump_data;
    logic                      r_dump_valid;
    logic                      r_busy;
    logic                      r_done;

    assign w_span      = END_ADDR - START_ADDR;
    assign w_handshake = (r_state == ST_WAIT_ACK) && r_dump_valid && DUMP_READY;

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and walk-counter logic.
    always_comb begin
        w_state_next  = r_state;
        w_addr_next   = r_addr;
        w_count_next  = r_count;
        w_settle_next = r_settle;
        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_state_next  = ST_SETTLE;
                    w_addr_next   = START_ADDR;
                    w_count_next  = {1'b0, w_span} + CNT_ONE;
                    w_settle_next = SETTLE_LOAD;
                end else begin
                    w_state_next  = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (r_settle == '0) begin
                    w_state_next  = ST_READ;
                end else begin
                    w_settle_next = r_settle - SW'(1'b1);
                end
            end
            ST_READ: begin
                w_state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_state_next = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (w_handshake) begin
                    w_count_next = r_count - CNT_ONE;
                    w_addr_next  = r_addr + {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
                    if (r_count == CNT_ONE) begin
                        w_state_next = ST_FINISH;
                    end else begin
                        w_state_next = ST_READ;
                    end
                end else begin
                    w_state_next = ST_WAIT_ACK;
                end
            end
            ST_FINISH: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Walk position, remaining-word and settle counters.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_addr   <= '0;
            r_count  <= '0;
            r_settle <= '0;
        end else begin
            r_addr   <= w_addr_next;
            r_count  <= w_count_next;
            r_settle <= w_settle_next;
        end
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_halt        <= 1'b0;
            r_address_bus <= '0;
            r_addr_oe     <= 1'b0;
            r_mem_rd      <= 1'b0;
            r_dump_addr   <= '0;
            r_dump_data   <= '0;
            r_dump_valid  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_halt        <= state_holds_halt(w_state_next);
            r_addr_oe     <= state_owns_bus(w_state_next);
            r_mem_rd      <= (w_state_next == ST_READ);
            r_address_bus <= state_owns_bus(w_state_next) ? w_addr_next : '0;
            r_busy        <= (w_state_next != ST_IDLE);
            r_done        <= (w_state_next == ST_FINISH);
            if (r_state == ST_CAPTURE) begin
                r_dump_valid <= 1'b1;
                r_dump_addr  <= r_addr;
                r_dump_data  <= DATA_BUS;
            end else if (w_handshake) begin
                r_dump_valid <= 1'b0;
            end else if (w_state_next == ST_IDLE) begin
                r_dump_addr  <= '0;
                r_dump_data  <= '0;
            end else begin
                r_dump_valid <= r_dump_valid;
            end
        end
    end

    assign HALT        = r_halt;
    assign ADDRESS_BUS = r_address_bus;
    assign ADDR_OE     = r_addr_oe;
    assign MEM_RD      = r_mem_rd;
    assign DUMP_ADDR   = r_dump_addr;
    assign DUMP_DATA   = r_dump_data;
    assign DUMP_VALID  = r_dump_valid;
    assign BUSY        = r_busy;
    assign DONE        = r_done;

endmodule
